// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
//   owner_e   : which port owns the response returning this cycle
//   rsp_tag_t : registered response tag {owner, is_read, err}
//   BAD_INSTR / DATA_ERR_RDATA : read data returned for out-of-range accesses
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  typedef struct packed {
    owner_e owner;
    logic   is_read;
    logic   err;
  } rsp_tag_t;

  localparam logic [31:0] BAD_INSTR      = 32'hdeadbeef;
  localparam logic [31:0] DATA_ERR_RDATA = 32'h0;

endpackage

// File: rtl/arb_starve_ctr.sv
// Priority decision between fetch and data with a starvation guard.
// Data wins conflicts until fetch has been denied STARVE_LIMIT cycles in a
// row; then fetch wins once and the wait count clears.
//   clk, rst       : clock, synchronous active-high reset
//   i_req, d_req   : fetch / data requests
//   sel_i, sel_d   : one-hot (or zero) grant selects, combinational
module arb_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic d_req,
  output logic sel_i,
  output logic sel_d
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] wait_cnt_q, wait_cnt_d;

  assign sel_i = !rst && i_req && (!d_req || (wait_cnt_q == LIMIT));
  assign sel_d = !rst && d_req && !sel_i;

  // Counts consecutive denied fetch cycles; saturates at LIMIT so the
  // compare above stays exact.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!i_req || sel_i) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != LIMIT) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= 4'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port synchronous SRAM (1-cycle read latency) between the
// CPU fetch port and data port. One access per cycle, response one cycle
// after grant, out-of-range accesses flagged and kept off the SRAM.
//   clk, rst                     : clock, synchronous active-high reset
//   i_req/i_addr -> i_gnt        : fetch request (read only), byte address
//   i_rvalid/i_rdata/i_err       : fetch response
//   d_req/d_addr/d_wen/d_wdata   : data request, d_wen==0 means read
//   d_gnt, d_rvalid/d_rdata/d_err: data grant and response
//   m_en/m_addr/m_wen/m_wdata    : SRAM drive; m_rdata returns next cycle
//   conflict_cnt                 : saturating count of i_req && d_req cycles
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_WORDS    = 1024,
  parameter int ADDR_W       = 10,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic [31:0]       d_addr,
  input  logic [3:0]        d_wen,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              m_en,
  output logic [ADDR_W-1:0] m_addr,
  output logic [3:0]        m_wen,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);

  logic        sel_i, sel_d;
  logic [31:0] acc_addr;
  logic        acc_err;
  rsp_tag_t    tag_q, tag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk  (clk),
    .rst  (rst),
    .i_req(i_req),
    .d_req(d_req),
    .sel_i(sel_i),
    .sel_d(sel_d)
  );

  assign i_gnt = sel_i;
  assign d_gnt = sel_d;

  // SRAM drive: out-of-range accesses are granted but never reach the SRAM.
  assign acc_addr = sel_i ? i_addr : d_addr;
  assign acc_err  = (acc_addr >= MEM_BYTES);
  assign m_en     = (sel_i || sel_d) && !acc_err;
  assign m_addr   = acc_addr[ADDR_W+1:2];
  assign m_wen    = (sel_d && !acc_err) ? d_wen : 4'b0000;
  assign m_wdata  = d_wdata;

  always_comb begin
    tag_d = '{owner: OWN_NONE, is_read: 1'b0, err: 1'b0};
    if (sel_i) begin
      tag_d = '{owner: OWN_I, is_read: 1'b1, err: acc_err};
    end else if (sel_d) begin
      tag_d = '{owner: OWN_D, is_read: (d_wen == 4'b0000), err: acc_err};
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (i_req && d_req && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Response stage: tag captured at grant, data muxed from m_rdata next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '{owner: OWN_NONE, is_read: 1'b0, err: 1'b0};
      cnt_q <= '0;
    end else begin
      tag_q <= tag_d;
      cnt_q <= cnt_d;
    end
  end

  assign i_rvalid = (tag_q.owner == OWN_I);
  assign i_err    = i_rvalid && tag_q.err;
  assign i_rdata  = !i_rvalid ? 32'h0 : (tag_q.err ? BAD_INSTR : m_rdata);

  assign d_rvalid = (tag_q.owner == OWN_D);
  assign d_err    = d_rvalid && tag_q.err;
  assign d_rdata  = !(d_rvalid && tag_q.is_read) ? 32'h0
                  : (tag_q.err ? DATA_ERR_RDATA : m_rdata);

  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_wen;
  logic        i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, m_en;
  logic [31:0] i_rdata, d_rdata, m_wdata;
  logic [31:0] m_rdata = 32'h0;
  logic [9:0]  m_addr;
  logic [3:0]  m_wen;
  logic [7:0]  conflict_cnt;

  logic [31:0] mem [1024];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .MEM_WORDS(1024), .ADDR_W(10), .STARVE_LIMIT(4), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_addr(d_addr), .d_wen(d_wen), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_en(m_en), .m_addr(m_addr), .m_wen(m_wen), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .conflict_cnt(conflict_cnt)
  );

  // Single-port SRAM model, 1-cycle read latency, byte write enables.
  always @(posedge clk) begin
    if (m_en) begin
      if (m_wen == 4'b0000) begin
        m_rdata <= mem[m_addr];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (m_wen[b]) mem[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
        end
      end
    end
  end

  typedef struct {
    logic        ir;   logic [31:0] ia;
    logic        dr;   logic [31:0] da; logic [3:0] dw; logic [31:0] dd;
    logic        eig;  logic edg; logic emen; logic [9:0] emaddr; logic [3:0] emwen;
    logic        eiv;  logic [31:0] eird; logic eie;
    logic        edv;  logic [31:0] edrd; logic ede;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int w = 0; w < 1024; w++) mem[w] = 32'h0;
    mem[10'h010] = 32'h00500093;
    mem[10'h001] = 32'hCAFEF00D;

    //         ir    ia           dr    da           dw     dd            eig   edg   emen  emaddr  emwen  eiv   eird          eie   edv   edrd          ede
    tbl[0]  = '{1'b1, 32'h40,     1'b0, 32'h0,     4'h0, 32'h0,        1'b1, 1'b0, 1'b1, 10'h010, 4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h0,      1'b1, 32'h200,   4'hF, 32'h4,        1'b0, 1'b1, 1'b1, 10'h080, 4'hF, 1'b1, 32'h00500093, 1'b0, 1'b0, 32'h0,        1'b0};
    tbl[2]  = '{1'b0, 32'h0,      1'b1, 32'h200,   4'h0, 32'h0,        1'b0, 1'b1, 1'b1, 10'h080, 4'h0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 32'h0,      1'b1, 32'h200,   4'hF, 32'h12345678, 1'b0, 1'b1, 1'b1, 10'h080, 4'hF, 1'b0, 32'h0,        1'b0, 1'b1, 32'h4,        1'b0};
    tbl[4]  = '{1'b0, 32'h0,      1'b1, 32'h200,   4'h1, 32'h000000AA, 1'b0, 1'b1, 1'b1, 10'h080, 4'h1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0};
    tbl[5]  = '{1'b0, 32'h0,      1'b1, 32'h200,   4'h0, 32'h0,        1'b0, 1'b1, 1'b1, 10'h080, 4'h0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0};
    tbl[6]  = '{1'b1, 32'h1000,   1'b0, 32'h0,     4'h0, 32'h0,        1'b1, 1'b0, 1'b0, 10'h000, 4'h0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h123456AA, 1'b0};
    tbl[7]  = '{1'b0, 32'h0,      1'b1, 32'h1004,  4'hF, 32'h55,       1'b0, 1'b1, 1'b0, 10'h000, 4'h0, 1'b1, 32'hdeadbeef, 1'b1, 1'b0, 32'h0,        1'b0};
    tbl[8]  = '{1'b0, 32'h0,      1'b1, 32'h4,     4'h0, 32'h0,        1'b0, 1'b1, 1'b1, 10'h001, 4'h0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b1};
    tbl[9]  = '{1'b0, 32'h0,      1'b0, 32'h0,     4'h0, 32'h0,        1'b0, 1'b0, 1'b0, 10'h000, 4'h0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hCAFEF00D, 1'b0};
    tbl[10] = '{1'b0, 32'h0,      1'b1, 32'h1000,  4'h0, 32'h0,        1'b0, 1'b1, 1'b0, 10'h000, 4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0};
    tbl[11] = '{1'b0, 32'h0,      1'b0, 32'h0,     4'h0, 32'h0,        1'b0, 1'b0, 1'b0, 10'h000, 4'h0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b1};
    tbl[12] = '{1'b0, 32'h0,      1'b0, 32'h0,     4'h0, 32'h0,        1'b0, 1'b0, 1'b0, 10'h000, 4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0};

    // Reset held with both ports requesting.
    rst = 1'b1; i_req = 1'b1; d_req = 1'b1;
    i_addr = 32'h40; d_addr = 32'h200; d_wen = 4'h0; d_wdata = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_i_gnt", i_gnt, 0);
      chk("rst_d_gnt", d_gnt, 0);
      chk("rst_m_en", m_en, 0);
      chk("rst_m_wen", m_wen, 0);
      chk("rst_i_rvalid", i_rvalid, 0);
      chk("rst_d_rvalid", d_rvalid, 0);
      chk("rst_conflict", conflict_cnt, 0);
    end
    next_cycle();
    rst = 1'b0;

    // Continuous conflict: data 4 cycles, fetch on the 5th, repeating.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("starve_d_gnt[%0d]", k), d_gnt, (k % 5) != 4);
      chk($sformatf("starve_i_gnt[%0d]", k), i_gnt, (k % 5) == 4);
      chk($sformatf("starve_cnt[%0d]", k), conflict_cnt, k);
      chk($sformatf("starve_i_rvalid[%0d]", k), i_rvalid, (k > 0) && ((k - 1) % 5 == 4));
      chk($sformatf("starve_d_rvalid[%0d]", k), d_rvalid, (k > 0) && ((k - 1) % 5 != 4));
      next_cycle();
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    next_cycle();

    // Directed single-requester vectors.
    for (int v = 0; v < 13; v++) begin
      i_req = tbl[v].ir; i_addr = tbl[v].ia;
      d_req = tbl[v].dr; d_addr = tbl[v].da; d_wen = tbl[v].dw; d_wdata = tbl[v].dd;
      @(negedge clk);
      chk($sformatf("v%0d_i_gnt", v), i_gnt, tbl[v].eig);
      chk($sformatf("v%0d_d_gnt", v), d_gnt, tbl[v].edg);
      chk($sformatf("v%0d_m_en", v), m_en, tbl[v].emen);
      chk($sformatf("v%0d_m_wen", v), m_wen, tbl[v].emwen);
      if (tbl[v].emen) chk($sformatf("v%0d_m_addr", v), m_addr, tbl[v].emaddr);
      chk($sformatf("v%0d_i_rvalid", v), i_rvalid, tbl[v].eiv);
      chk($sformatf("v%0d_i_rdata", v), i_rdata, tbl[v].eird);
      chk($sformatf("v%0d_i_err", v), i_err, tbl[v].eie);
      chk($sformatf("v%0d_d_rvalid", v), d_rvalid, tbl[v].edv);
      chk($sformatf("v%0d_d_rdata", v), d_rdata, tbl[v].edrd);
      chk($sformatf("v%0d_d_err", v), d_err, tbl[v].ede);
      next_cycle();
    end
    chk("mem_word1_untouched", mem[10'h001], 32'hCAFEF00D);
    chk("conflict_hold", conflict_cnt, 10);

    // Reset arriving right after a data read grant kills the response.
    d_req = 1'b1; d_addr = 32'h200; d_wen = 4'h0;
    @(negedge clk);
    chk("mid_d_gnt", d_gnt, 1);
    rst = 1'b1;
    next_cycle();
    d_req = 1'b0;
    @(negedge clk);
    chk("mid_d_rvalid", d_rvalid, 0);
    chk("mid_d_gnt_rst", d_gnt, 0);
    chk("mid_conflict", conflict_cnt, 0);
    next_cycle();
    rst = 1'b0;

    // Conflict counter saturates at all-ones (8-bit instance here).
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h40; d_addr = 32'h200; d_wen = 4'h0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (k == 100) chk("sat_cnt_100", conflict_cnt, 100);
      if (k == 255) chk("sat_cnt_255", conflict_cnt, 255);
      if (k == 299) chk("sat_cnt_299", conflict_cnt, 255);
      next_cycle();
    end
    i_req = 1'b0; d_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port synchronous SRAM (1-cycle read latency) between the CPU instruction-fetch port and the data port.
- Replaces the two separate idealised memories used in simulation so that cpu_top can run against a single physical memory.
- Fixed priority to data, with a starvation guard for fetch.
- Issues at most one access per cycle, returns a tagged response one cycle later, and flags out-of-range accesses.

Parameters:
- MEM_WORDS, 1024, memory depth in 32-bit words.
- ADDR_W, 10, word-address width (clog2(MEM_WORDS)).
- STARVE_LIMIT, 4, consecutive denied fetch cycles after which fetch wins; legal range 1..15.
- CNT_W, 16, conflict counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request (read only).
- i_addr  in  32  fetch byte address; bits [1:0] ignored.
- i_gnt  out  1  fetch accepted this cycle (combinational).
- i_rvalid  out  1  fetch response valid (registered).
- i_rdata  out  32  fetch read data.
- i_err  out  1  fetch response was out of range; qualified by i_rvalid.
- d_req  in  1  data request.
- d_addr  in  32  data byte address; bits [1:0] ignored.
- d_wen  in  4  byte write enables; 4'b0000 = read.
- d_wdata  in  32  write data.
- d_gnt  out  1  data accepted this cycle (combinational).
- d_rvalid  out  1  data response or write acknowledge (registered).
- d_rdata  out  32  data read data; 0 for writes.
- d_err  out  1  data response was out of range.
- m_en  out  1  SRAM access enable.
- m_addr  out  ADDR_W  SRAM word address.
- m_wen  out  4  SRAM byte write enables.
- m_wdata  out  32  SRAM write data.
- m_rdata  in  32  SRAM read data; valid the cycle after m_en with m_wen==0.
- conflict_cnt  out  CNT_W  saturating count of cycles with i_req && d_req.

Behaviour:
- Reset (rst=1 at posedge):
  - i_rvalid, d_rvalid, i_err, d_err = 0; i_rdata, d_rdata = 0; conflict_cnt = 0; wait counter = 0; response tag = NONE.
  - While rst=1: i_gnt = d_gnt = m_en = 0 and m_wen = 0, regardless of requests.
  - A request granted the cycle before reset asserts produces no response; its SRAM write has already occurred.
- Arbitration is combinational each cycle:
  - Only d_req: data granted.
  - Only i_req: fetch granted.
  - Both: fetch granted if wait_cnt == STARVE_LIMIT, else data granted.
  - Exactly one or zero grants per cycle; a requester must hold req and address until it sees gnt.
- Wait counter: increments when i_req && !i_gnt; clears on i_gnt or when i_req = 0; never exceeds STARVE_LIMIT.
- SRAM drive on grant:
  - In range: m_en = 1, m_addr = addr[ADDR_W+1:2]; m_wen = d_wen for data, 0 for fetch; m_wdata = d_wdata.
  - Out of range (addr >= 4*MEM_WORDS): m_en = 0 and the write is dropped.
- Response is registered and tagged {owner, is_read, err}; it appears in the cycle after the grant.
  - Fetch: i_rvalid = 1; i_rdata = m_rdata, or 32'hdeadbeef if err; i_err = err.
  - Data read: d_rvalid = 1; d_rdata = m_rdata, or 32'h0 if err.
  - Data write: d_rvalid = 1; d_rdata = 0; d_err = err.
  - rvalid of the non-owner = 0. rvalid is a single-cycle pulse; back-to-back grants give back-to-back pulses.
- Read data is passed through combinationally from m_rdata in the response cycle (no extra register) and is muxed by the tag.
- Partial-byte writes go to the SRAM unchanged; the arbiter does no read-modify-write.
- conflict_cnt: increments when i_req && d_req && !rst; saturates at all-ones.
- Latency: grant to response = 1 cycle. Throughput: 1 access per cycle.

Decomposition:
- Package mem_arb_pkg holds:
  - owner enum {OWN_NONE, OWN_I, OWN_D};
  - response-tag struct;
  - constants BAD_INSTR = 32'hdeadbeef and DATA_ERR_RDATA = 32'h0.
- Sub-module arb_starve_ctr: the wait counter plus the priority decision, with inputs i_req, d_req, rst and outputs sel_i, sel_d.
- The top level holds the SRAM drive, the response tag register and the conflict counter.

Test Plan:
- Reset: hold rst=1 for 3 cycles with i_req = d_req = 1 -> gnts = 0, m_en = 0, all rvalid = 0, conflict_cnt = 0; release rst -> d_gnt in the first cycle.
- Fetch only: preload word 0x10 = 0x00500093; i_addr = 0x40 -> i_gnt same cycle, m_addr = 0x10, next cycle i_rvalid = 1, i_rdata = 0x00500093, i_err = 0.
- Data write then read: d_wen = 4'b1111, d_addr = 0x200, d_wdata = 4 -> d_rvalid pulse with d_rdata = 0; then read 0x200 -> d_rdata = 4. Repeat with d_wen = 4'b0001 and wdata 0xAA onto 0x12345678 -> read returns 0x123456AA.
- Starvation: i_req and d_req held continuously with STARVE_LIMIT = 4 -> data granted 4 cycles, fetch on the 5th, pattern repeats; conflict_cnt increments every cycle.
- Out of range: i_addr = 0x1000 -> i_gnt, m_en = 0, i_rvalid with i_rdata = 0xdeadbeef, i_err = 1; write to 0x1004 -> d_err = 1, memory unchanged.
- Reset mid-flight: data read granted at cycle N, rst=1 at N+1 -> no d_rvalid at N+1; conflict_cnt preset near max (0xFFFF) saturates, does not wrap.
